// File: rtl/axi_pkg.sv
// Shared definitions for the data-cache AXI bridge: FSM state encodings,
// AXI burst/response codes and the cache-line field geometry.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // 64-byte cache lines: the line tag is address bits [31:6].
    localparam int LINE_LSB = 6;
    localparam int LINE_W   = 32 - LINE_LSB;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wstate_e;

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// AXI4 master-side channel bundle (AR/R/AW/W/B) between the bridge and the
// system interconnect. The bridge uses the master modport.
interface dcache_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/line_hazard_cmp.sv
// Read-after-write line hazard detect: a read must not start while the same
// cache line is being written back, either by a write already in flight or
// by a write being accepted in this very cycle.
module line_hazard_cmp
    import axi_pkg::*;
(
    input  logic              w_busy_i,
    input  logic [LINE_W-1:0] pend_line_i,
    input  logic              w_acc_i,
    input  logic [LINE_W-1:0] r_line_i,
    input  logic [LINE_W-1:0] w_line_i,
    output logic              hazard_o
);

    assign hazard_o = (w_busy_i && (r_line_i == pend_line_i)) ||
                      (w_acc_i  && (r_line_i == w_line_i));

endmodule

// File: rtl/dcache_axi_bridge.sv
// Bridges the dcache miss/write-back request interface onto AXI4 master
// channels. One read and one write may be outstanding; a read to a line
// whose write-back has not yet received its B response is held off.
module dcache_axi_bridge
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    // cache read side
    input  logic        r_req,
    input  logic [31:0] r_addr,
    input  logic [2:0]  r_size,
    input  logic [7:0]  r_length,
    output logic        r_rdy,
    output logic        ret_valid,
    output logic        ret_last,
    output logic [31:0] r_data_AXI,
    input  logic        r_data_ready,
    // cache write side
    input  logic        w_req,
    input  logic [31:0] w_addr,
    input  logic [2:0]  w_size,
    input  logic [7:0]  w_length,
    output logic        w_rdy,
    input  logic        w_data_req,
    input  logic [31:0] w_data_AXI,
    input  logic [3:0]  w_strb,
    input  logic        w_last,
    output logic        w_data_ready,
    output logic        b_valid,
    input  logic        b_ready,
    output logic        bus_err,
    // AXI master channels
    dcache_axi_bridge_if.master axi
);

    rstate_e           rstate_q, rstate_d;
    wstate_e           wstate_q, wstate_d;

    logic [31:0]       araddr_q;
    logic [7:0]        arlen_q;
    logic [2:0]        arsize_q;
    logic [31:0]       awaddr_q;
    logic [7:0]        awlen_q;
    logic [2:0]        awsize_q;
    logic [LINE_W-1:0] pend_line_q;
    logic              bus_err_q, bus_err_d;

    logic              hazard;
    logic              r_acc;
    logic              w_acc;
    logic              r_beat;
    logic              b_beat;

    line_hazard_cmp u_line_hazard_cmp (
        .w_busy_i    (wstate_q != W_IDLE),
        .pend_line_i (pend_line_q),
        .w_acc_i     (w_acc),
        .r_line_i    (r_addr[31:LINE_LSB]),
        .w_line_i    (w_addr[31:LINE_LSB]),
        .hazard_o    (hazard)
    );

    assign w_rdy  = (wstate_q == W_IDLE);
    assign w_acc  = w_req && w_rdy;
    assign r_rdy  = (rstate_q == R_IDLE) && !hazard;
    assign r_acc  = r_req && r_rdy;
    assign r_beat = (rstate_q == R_DATA) && axi.rvalid && r_data_ready;
    assign b_beat = (wstate_q == W_RESP) && axi.bvalid && b_ready;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = AXI_BURST_INCR;
    assign bus_err     = bus_err_q;

    // Read FSM next state and AR/R channel steering.
    always_comb begin
        rstate_d    = rstate_q;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        ret_valid   = 1'b0;
        ret_last    = 1'b0;
        r_data_AXI  = '0;
        case (rstate_q)
            R_IDLE: begin
                if (r_acc) rstate_d = R_AR;
            end
            R_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) rstate_d = R_DATA;
            end
            R_DATA: begin
                ret_valid  = axi.rvalid;
                ret_last   = axi.rlast;
                r_data_AXI = axi.rdata;
                axi.rready = r_data_ready;
                if (r_beat && axi.rlast) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Write FSM next state and AW/W/B channel steering.
    always_comb begin
        wstate_d     = wstate_q;
        axi.awvalid  = 1'b0;
        axi.wvalid   = 1'b0;
        axi.wdata    = '0;
        axi.wstrb    = '0;
        axi.wlast    = 1'b0;
        axi.bready   = 1'b0;
        w_data_ready = 1'b0;
        b_valid      = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (w_acc) wstate_d = W_AW;
            end
            W_AW: begin
                axi.awvalid = 1'b1;
                if (axi.awready) wstate_d = W_DATA;
            end
            W_DATA: begin
                axi.wvalid   = w_data_req;
                axi.wdata    = w_data_AXI;
                axi.wstrb    = w_strb;
                axi.wlast    = w_last;
                w_data_ready = axi.wready;
                if (w_data_req && axi.wready && w_last) wstate_d = W_RESP;
            end
            W_RESP: begin
                b_valid    = axi.bvalid;
                axi.bready = b_ready;
                if (b_beat) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Error pulse for the cycle after a non-OKAY R beat or B response.
    always_comb begin
        bus_err_d = (r_beat && (axi.rresp != AXI_RESP_OKAY)) ||
                    (b_beat && (axi.bresp != AXI_RESP_OKAY));
    end

    // State registers for both FSMs and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            wstate_q  <= W_IDLE;
            bus_err_q <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            wstate_q  <= wstate_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Capture request fields on acceptance; they stay stable through AR/AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            pend_line_q <= '0;
        end else begin
            if (r_acc) begin
                araddr_q <= r_addr;
                arlen_q  <= r_length;
                arsize_q <= r_size;
            end
            if (w_acc) begin
                awaddr_q    <= w_addr;
                awlen_q     <= w_length;
                awsize_q    <= w_size;
                pend_line_q <= w_addr[31:LINE_LSB];
            end
        end
    end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Randomized self-checking bench for dcache_axi_bridge. The bench plays both
// the dcache and the AXI slave, and predicts every observable from the
// request/handshake rules directly.
module tb_dcache_axi_bridge;

    localparam logic [3:0] ID = 4'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_req, r_rdy, ret_valid, ret_last, r_data_ready;
    logic [31:0] r_addr, r_data_AXI;
    logic [2:0]  r_size;
    logic [7:0]  r_length;
    logic        w_req, w_rdy, w_data_req, w_last, w_data_ready, b_valid, b_ready, bus_err;
    logic [31:0] w_addr, w_data_AXI;
    logic [2:0]  w_size;
    logic [7:0]  w_length;
    logic [3:0]  w_strb;

    int checks = 0;
    int errors = 0;

    dcache_axi_bridge_if axi ();

    dcache_axi_bridge #(.AXI_ID(ID)) dut (
        .clk(clk), .rst(rst),
        .r_req(r_req), .r_addr(r_addr), .r_size(r_size), .r_length(r_length),
        .r_rdy(r_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
        .r_data_AXI(r_data_AXI), .r_data_ready(r_data_ready),
        .w_req(w_req), .w_addr(w_addr), .w_size(w_size), .w_length(w_length),
        .w_rdy(w_rdy), .w_data_req(w_data_req), .w_data_AXI(w_data_AXI),
        .w_strb(w_strb), .w_last(w_last), .w_data_ready(w_data_ready),
        .b_valid(b_valid), .b_ready(b_ready), .bus_err(bus_err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        r_req = 0; r_addr = 0; r_size = 0; r_length = 0; r_data_ready = 0;
        w_req = 0; w_addr = 0; w_size = 0; w_length = 0;
        w_data_req = 0; w_data_AXI = 0; w_strb = 0; w_last = 0; b_ready = 0;
        axi.arready = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        step();
        step();
        @(negedge clk);
        checks++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, ret_valid,
             ret_last, b_valid, w_data_ready, bus_err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_valids got %b want 0", {axi.arvalid, axi.awvalid, axi.wvalid,
                     axi.rready, axi.bready, ret_valid, ret_last, b_valid, w_data_ready, bus_err});
        end
        checks++;
        if ({axi.araddr, axi.arlen, axi.arsize, axi.awaddr, axi.awlen, axi.awsize} !== 86'd0) begin
            errors++;
            $display("FAIL reset_fields got araddr=%h awaddr=%h want 0", axi.araddr, axi.awaddr);
        end
        rst = 0;
        step();
        @(negedge clk);
        checks++;
        if ({r_rdy, w_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_rdy got %b want 11", {r_rdy, w_rdy});
        end
        checks++;
        if ({axi.arburst, axi.awburst, axi.arid, axi.awid} !== {2'b01, 2'b01, ID, ID}) begin
            errors++;
            $display("FAIL const_fields got %h want %h", {axi.arburst, axi.awburst, axi.arid, axi.awid},
                     {2'b01, 2'b01, ID, ID});
        end
        step();
    endtask

    // One complete read burst with random AR latency and random R/ready gaps.
    task automatic test_read(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input int err_beat);
        logic [31:0] exp_data[$];
        int beat, cyc, wait_ar;
        logic exp_err, rv, rd, hs;
        for (int i = 0; i <= int'(len); i++) exp_data.push_back($urandom);
        r_req = 1; r_addr = addr; r_length = len; r_size = size;
        @(negedge clk);
        checks++;
        if (r_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rd_accept r_rdy got %b want 1", r_rdy);
        end
        step();
        r_req = 0; r_addr = $urandom; r_length = 8'($urandom); r_size = 3'($urandom);
        r_data_ready = 1;
        wait_ar = $urandom_range(0, 3);
        for (int k = 0; k <= wait_ar; k++) begin
            axi.arready = (k == wait_ar);
            @(negedge clk);
            checks++;
            if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} !==
                {1'b1, addr, len, size, 2'b01}) begin
                errors++;
                $display("FAIL ar_payload got v=%b a=%h l=%0d s=%0d want v=1 a=%h l=%0d s=%0d",
                         axi.arvalid, axi.araddr, axi.arlen, axi.arsize, addr, len, size);
            end
            checks++;
            if ({axi.rready, ret_valid} !== 2'b00) begin
                errors++;
                $display("FAIL ar_rgate got %b want 00", {axi.rready, ret_valid});
            end
            step();
        end
        axi.arready = 0;
        beat = 0; cyc = 0; exp_err = 0;
        while (beat <= int'(len) && cyc < 400) begin
            rv = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            axi.rvalid = rv; r_data_ready = rd;
            axi.rdata = exp_data[beat];
            axi.rlast = (beat == int'(len));
            axi.rresp = (beat == err_beat) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if ({ret_valid, axi.rready, ret_last} !== {rv, rd, beat == int'(len)}) begin
                errors++;
                $display("FAIL r_ctrl beat %0d got %b want %b", beat,
                         {ret_valid, axi.rready, ret_last}, {rv, rd, beat == int'(len)});
            end
            checks++;
            if (r_data_AXI !== exp_data[beat]) begin
                errors++;
                $display("FAIL r_data beat %0d got %h want %h", beat, r_data_AXI, exp_data[beat]);
            end
            checks++;
            if (bus_err !== exp_err) begin
                errors++;
                $display("FAIL rd_bus_err beat %0d got %b want %b", beat, bus_err, exp_err);
            end
            hs = rv && rd;
            exp_err = hs && (beat == err_beat);
            step();
            if (hs) beat++;
            cyc++;
        end
        axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; r_data_ready = 1;
        checks++;
        if (beat <= int'(len)) begin
            errors++;
            $display("FAIL rd_timeout got %0d beats want %0d", beat, int'(len) + 1);
        end
        @(negedge clk);
        checks++;
        if ({r_rdy, axi.rready, ret_valid, bus_err} !== {1'b1, 1'b0, 1'b0, exp_err}) begin
            errors++;
            $display("FAIL rd_done got %b want %b", {r_rdy, axi.rready, ret_valid, bus_err},
                     {1'b1, 1'b0, 1'b0, exp_err});
        end
        r_data_ready = 0;
        step();
    endtask

    // One complete write-back. hold_rd keeps a same-line read request up
    // throughout; otherwise r_addr wanders to probe the hazard comparator.
    task automatic test_write(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input bit hold_rd,
                              input logic [1:0] bresp_v, input bit toggle_wr);
        int beat, cyc, wait_aw;
        logic wd, wr, hs, bv, br, last;
        logic [31:0] d;
        logic [3:0] s;
        w_req = 1; w_addr = addr; w_length = len; w_size = size;
        r_req = hold_rd;
        r_addr = (hold_rd || $urandom_range(0, 1) == 1) ? {addr[31:6], 6'($urandom)} : $urandom;
        @(negedge clk);
        checks++;
        if ({w_rdy, r_rdy} !== {1'b1, r_addr[31:6] != addr[31:6]}) begin
            errors++;
            $display("FAIL wr_accept got %b want %b", {w_rdy, r_rdy}, {1'b1, r_addr[31:6] != addr[31:6]});
        end
        step();
        w_req = 0; w_addr = $urandom; w_length = 8'($urandom); w_size = 3'($urandom);
        w_data_req = 1; axi.wready = 1;
        wait_aw = $urandom_range(0, 3);
        for (int k = 0; k <= wait_aw; k++) begin
            axi.awready = (k == wait_aw);
            if (!hold_rd) r_addr = ($urandom_range(0, 1) == 1) ? {addr[31:6], 6'($urandom)} : $urandom;
            @(negedge clk);
            checks++;
            if ({axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid} !==
                {1'b1, addr, len, size, 2'b01, ID}) begin
                errors++;
                $display("FAIL aw_payload got v=%b a=%h l=%0d want v=1 a=%h l=%0d",
                         axi.awvalid, axi.awaddr, axi.awlen, addr, len);
            end
            checks++;
            if ({axi.wvalid, w_data_ready, axi.arvalid, r_rdy} !==
                {1'b0, 1'b0, 1'b0, r_addr[31:6] != addr[31:6]}) begin
                errors++;
                $display("FAIL aw_gate got %b want %b", {axi.wvalid, w_data_ready, axi.arvalid, r_rdy},
                         {1'b0, 1'b0, 1'b0, r_addr[31:6] != addr[31:6]});
            end
            step();
        end
        axi.awready = 0;
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 400) begin
            wd = ($urandom_range(0, 3) != 0);
            wr = toggle_wr ? cyc[0] : ($urandom_range(0, 3) != 0);
            d = $urandom; s = 4'($urandom); last = (beat == int'(len));
            w_data_req = wd; axi.wready = wr; w_data_AXI = d; w_strb = s; w_last = last;
            if (!hold_rd) r_addr = ($urandom_range(0, 1) == 1) ? {addr[31:6], 6'($urandom)} : $urandom;
            @(negedge clk);
            checks++;
            if ({axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, w_data_ready} !== {wd, d, s, last, wr}) begin
                errors++;
                $display("FAIL w_beat %0d got v=%b d=%h s=%h l=%b rdy=%b want v=%b d=%h s=%h l=%b rdy=%b",
                         beat, axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, w_data_ready, wd, d, s, last, wr);
            end
            checks++;
            if (r_rdy !== (r_addr[31:6] != addr[31:6])) begin
                errors++;
                $display("FAIL w_hazard got r_rdy=%b want %b", r_rdy, r_addr[31:6] != addr[31:6]);
            end
            hs = wd && wr;
            step();
            if (hs) beat++;
            cyc++;
        end
        w_data_req = 0; w_last = 0;
        checks++;
        if (beat <= int'(len)) begin
            errors++;
            $display("FAIL wr_timeout got %0d beats want %0d", beat, int'(len) + 1);
        end
        hs = 0; cyc = 0;
        while (!hs && cyc < 100) begin
            bv = ($urandom_range(0, 2) != 0);
            br = ($urandom_range(0, 2) != 0);
            axi.bvalid = bv; b_ready = br; axi.bresp = bresp_v;
            if (!hold_rd) r_addr = ($urandom_range(0, 1) == 1) ? {addr[31:6], 6'($urandom)} : $urandom;
            @(negedge clk);
            checks++;
            if ({b_valid, axi.bready, axi.wvalid, r_rdy} !== {bv, br, 1'b0, r_addr[31:6] != addr[31:6]}) begin
                errors++;
                $display("FAIL b_phase got %b want %b", {b_valid, axi.bready, axi.wvalid, r_rdy},
                         {bv, br, 1'b0, r_addr[31:6] != addr[31:6]});
            end
            hs = bv && br;
            step();
            cyc++;
        end
        axi.bvalid = 0; b_ready = 0; axi.bresp = 0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL b_timeout got no handshake want handshake");
        end
        @(negedge clk);
        checks++;
        if ({w_rdy, r_rdy, bus_err} !== {1'b1, 1'b1, bresp_v != 2'b00}) begin
            errors++;
            $display("FAIL wr_done got %b want %b", {w_rdy, r_rdy, bus_err}, {1'b1, 1'b1, bresp_v != 2'b00});
        end
        r_req = 0;
        step();
        checks++;
        if (axi.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_stray_read got arvalid=%b want 0", axi.arvalid);
        end
    endtask

    // Distinct-line read and write in one cycle, both transfer; then a global
    // reset abandons them from the beat states.
    task automatic test_simultaneous();
        w_req = 1; w_addr = 32'h3000_0000; w_length = 8'd3; w_size = 3'd2;
        r_req = 1; r_addr = 32'h3000_0040; r_length = 8'd7; r_size = 3'd2;
        @(negedge clk);
        checks++;
        if ({r_rdy, w_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL sim_accept got %b want 11", {r_rdy, w_rdy});
        end
        step();
        r_req = 0; w_req = 0;
        @(negedge clk);
        checks++;
        if ({axi.arvalid, axi.awvalid, axi.araddr, axi.awaddr} !==
            {1'b1, 1'b1, 32'h3000_0040, 32'h3000_0000}) begin
            errors++;
            $display("FAIL sim_issue got ar=%b aw=%b araddr=%h awaddr=%h want 1 1 30000040 30000000",
                     axi.arvalid, axi.awvalid, axi.araddr, axi.awaddr);
        end
        axi.arready = 1; axi.awready = 1;
        step();
        axi.arready = 0; axi.awready = 0;
        rst = 1;
        axi.rvalid = 1; axi.rlast = 1; r_data_ready = 1;
        w_data_req = 1; axi.wready = 1; axi.bvalid = 1; b_ready = 1;
        step();
        @(negedge clk);
        checks++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, ret_valid,
             ret_last, b_valid, w_data_ready} !== 9'd0) begin
            errors++;
            $display("FAIL sim_reset got %b want 0", {axi.arvalid, axi.awvalid, axi.wvalid,
                     axi.rready, axi.bready, ret_valid, ret_last, b_valid, w_data_ready});
        end
        rst = 0;
        idle_inputs();
        step();
    endtask

    // Reset asserted while the read FSM is mid-burst.
    task automatic test_reset_in_read();
        r_req = 1; r_addr = 32'h5000_0000; r_length = 8'd15; r_size = 3'd2;
        step();
        r_req = 0; axi.arready = 1;
        step();
        axi.arready = 0; axi.rvalid = 1; r_data_ready = 1; axi.rdata = 32'hCAFE_0001; axi.rlast = 0;
        step();
        @(negedge clk);
        checks++;
        if ({ret_valid, r_data_AXI} !== {1'b1, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL rr_mid got v=%b d=%h want 1 cafe0001", ret_valid, r_data_AXI);
        end
        rst = 1; axi.rlast = 1; axi.rresp = 2'b10;
        w_data_req = 1; axi.wready = 1; axi.bvalid = 1; b_ready = 1;
        step();
        @(negedge clk);
        checks++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, ret_valid,
             ret_last, b_valid, w_data_ready, bus_err} !== 10'd0) begin
            errors++;
            $display("FAIL rr_reset_valids got %b want 0", {axi.arvalid, axi.awvalid, axi.wvalid,
                     axi.rready, axi.bready, ret_valid, ret_last, b_valid, w_data_ready, bus_err});
        end
        checks++;
        if ({axi.araddr, axi.arlen} !== 40'd0) begin
            errors++;
            $display("FAIL rr_reset_fields got %h/%0d want 0", axi.araddr, axi.arlen);
        end
        rst = 0;
        step();
        @(negedge clk);
        checks++;
        if ({r_rdy, w_rdy, ret_valid, axi.rready} !== 4'b1100) begin
            errors++;
            $display("FAIL rr_after got %b want 1100", {r_rdy, w_rdy, ret_valid, axi.rready});
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1)
                test_read($urandom, 8'($urandom_range(0, 7)), 3'd2, -1);
            else
                test_write($urandom, 8'($urandom_range(0, 7)), 3'd2, 1'b0,
                           ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_read(32'h1000_0040, 8'd15, 3'd2, -1);
        test_write(32'h2000_0080, 8'd15, 3'd2, 1'b0, 2'b00, 1'b1);
        test_write(32'h2000_0080, 8'd15, 3'd2, 1'b1, 2'b00, 1'b0);
        test_read(32'h2000_0084, 8'd15, 3'd2, -1);
        test_simultaneous();
        test_read(32'h1000_0040, 8'd7, 3'd2, 2);
        test_write(32'h6000_01C0, 8'd3, 3'd2, 1'b0, 2'b10, 1'b0);
        test_random_mix();
        test_reset_in_read();
        test_read(32'h7000_0000, 8'd0, 3'd2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
